// File: rtl/cmac_aes128_ctrl_pkg.sv
// cmac_aes128_ctrl_pkg: shared state encoding, block width, Rb constant and GF(2^128) doubling
package cmac_aes128_ctrl_pkg;
    localparam int BLK_W = 128;
    localparam logic [BLK_W-1:0] RB = BLK_W'(8'h87);
    typedef enum logic [2:0] {IDLE, SUBKEY, WAIT_BLK, ENC, FINAL} state_t;
    function automatic logic [BLK_W-1:0] dbl(input logic [BLK_W-1:0] v);
        return {v[BLK_W-2:0], 1'b0} ^ (v[BLK_W-1] ? RB : '0);
    endfunction
endpackage

// File: rtl/cmac_aes128_ctrl_if.sv
// cmac_aes128_ctrl_if: host message stream, external AES core handshake and tag result
//   slave  : the CMAC controller side
//   master : the host / AES core side
interface cmac_aes128_ctrl_if;
    import cmac_aes128_ctrl_pkg::*;
    logic [BLK_W-1:0] key;
    logic             start;
    logic             msg_valid;
    logic             msg_ready;
    logic [BLK_W-1:0] msg_data;
    logic             msg_last;
    logic [4:0]       msg_bytes;
    logic [BLK_W-1:0] aes_key;
    logic [BLK_W-1:0] aes_in;
    logic             aes_start;
    logic             aes_done;
    logic [BLK_W-1:0] aes_out;
    logic [BLK_W-1:0] tag;
    logic             tag_valid;
    logic             busy;
    logic             error;
    modport slave (
        input  key, start, msg_valid, msg_data, msg_last, msg_bytes, aes_done, aes_out,
        output msg_ready, aes_key, aes_in, aes_start, tag, tag_valid, busy, error
    );
    modport master (
        output key, start, msg_valid, msg_data, msg_last, msg_bytes, aes_done, aes_out,
        input  msg_ready, aes_key, aes_in, aes_start, tag, tag_valid, busy, error
    );
endinterface

// File: rtl/cmac_aes128_ctrl_subkey_pad.sv
// cmac_subkey_pad: combinational CMAC subkey doubling and last-block 10* padding
//   l_i     : L = AES_K(0)
//   data_i  : last message block, byte 0 in the top byte
//   bytes_i : valid bytes in data_i (values above 16 keep the whole block)
//   k1_o/k2_o : derived subkeys, pad_o : padded block
module cmac_subkey_pad
    import cmac_aes128_ctrl_pkg::*;
(
    input  logic [BLK_W-1:0] l_i,
    input  logic [BLK_W-1:0] data_i,
    input  logic [4:0]       bytes_i,
    output logic [BLK_W-1:0] k1_o,
    output logic [BLK_W-1:0] k2_o,
    output logic [BLK_W-1:0] pad_o
);
    assign k1_o = dbl(l_i);
    assign k2_o = dbl(k1_o);
    always_comb begin
        pad_o = '0;
        for (int i = 0; i < 16; i++)
            pad_o[BLK_W-1-8*i -: 8] = (5'(i) < bytes_i) ? data_i[BLK_W-1-8*i -: 8] :
                                      (5'(i) == bytes_i) ? 8'h80 : 8'h00;
    end
endmodule

// File: rtl/cmac_aes128_ctrl.sv
// cmac_aes128_ctrl: AES-CMAC tag controller driving an external AES-128 encrypt core
//   clk, reset : clock and asynchronous active-high reset
//   bus        : message stream in, AES core launch/result, tag/busy/error out
//   AES_TIMEOUT: cycles to wait for aes_done after a launch (0 = wait forever)
module cmac_aes128_ctrl
    import cmac_aes128_ctrl_pkg::*;
#(
    parameter int unsigned AES_TIMEOUT = 255
) (
    input logic               clk,
    input logic               reset,
    cmac_aes128_ctrl_if.slave bus
);
    state_t state_q, state_d;
    logic [BLK_W-1:0] x_q, x_d, k1_q, k1_d, k2_q, k2_d, key_q, key_d;
    logic [BLK_W-1:0] tag_q, tag_d, aes_in_q, aes_in_d;
    logic aes_start_q, aes_start_d, tag_valid_q, tag_valid_d, err_q, err_d;
    logic [31:0] tmo_q, tmo_d;
    logic [BLK_W-1:0] k1, k2, pad;
    logic full, waiting;

    cmac_subkey_pad u_sp (
        .l_i    (bus.aes_out),
        .data_i (bus.msg_data),
        .bytes_i(bus.msg_bytes),
        .k1_o   (k1),
        .k2_o   (k2),
        .pad_o  (pad)
    );

    assign full    = bus.msg_bytes >= 5'd16;
    assign waiting = state_q inside {SUBKEY, ENC, FINAL};

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        k1_d        = k1_q;
        k2_d        = k2_q;
        key_d       = key_q;
        tag_d       = tag_q;
        aes_in_d    = aes_in_q;
        aes_start_d = 1'b0;
        tag_valid_d = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE: if (bus.start) begin
                key_d       = bus.key;
                x_d         = '0;
                err_d       = 1'b0;
                aes_in_d    = '0;
                aes_start_d = 1'b1;
                state_d     = SUBKEY;
            end
            SUBKEY: if (bus.aes_done) begin
                k1_d    = k1;
                k2_d    = k2;
                state_d = WAIT_BLK;
            end
            WAIT_BLK: if (bus.msg_valid) begin
                aes_start_d = 1'b1;
                aes_in_d    = x_q ^ (!bus.msg_last ? bus.msg_data :
                                     full ? bus.msg_data ^ k1_q : pad ^ k2_q);
                state_d     = bus.msg_last ? FINAL : ENC;
            end
            ENC: if (bus.aes_done) begin
                x_d     = bus.aes_out;
                state_d = WAIT_BLK;
            end
            FINAL: if (bus.aes_done) begin
                tag_d       = bus.aes_out;
                tag_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // tmo_q counts cycles since the last launch; it reaches AES_TIMEOUT-1 on the last allowed cycle
        if (AES_TIMEOUT != 0 && waiting && !bus.aes_done && tmo_q == AES_TIMEOUT - 1) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end
        tmo_d = aes_start_d ? '0 : tmo_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            k1_q        <= '0;
            k2_q        <= '0;
            key_q       <= '0;
            tag_q       <= '0;
            aes_in_q    <= '0;
            aes_start_q <= 1'b0;
            tag_valid_q <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            k1_q        <= k1_d;
            k2_q        <= k2_d;
            key_q       <= key_d;
            tag_q       <= tag_d;
            aes_in_q    <= aes_in_d;
            aes_start_q <= aes_start_d;
            tag_valid_q <= tag_valid_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.msg_ready = state_q == WAIT_BLK;
    assign bus.busy      = state_q != IDLE;
    assign bus.aes_key   = key_q;
    assign bus.aes_in    = aes_in_q;
    assign bus.aes_start = aes_start_q;
    assign bus.tag       = tag_q;
    assign bus.tag_valid = tag_valid_q;
    assign bus.error     = err_q;
endmodule

// File: tb/tb_cmac_aes128_ctrl.sv
// tb_cmac_aes128_ctrl: directed RFC 4493 vectors against a behavioural AES-128 core
module tb_cmac_aes128_ctrl;
    localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1  = 128'hfbeed618357133667c85e08f7236a8de;
    localparam logic [127:0] K2  = 128'hf7ddac306ae266ccf90bc11ee46d513b;
    localparam logic [127:0] T0  = 128'hbb1d6929e95937287fa37d129b756746;
    localparam logic [127:0] T16 = 128'h070a16b46b4d4144f79bdd9dd04a287c;
    localparam logic [127:0] T40 = 128'hdfa66747de9ae63030ca32611497c827;
    localparam logic [127:0] T64 = 128'h51f0bebf7e3b9d92fc49741779363cfe;

    logic clk, reset;
    int n_tests, n_fail, tv_cnt, lat;
    bit gaps;
    logic [7:0] sb [256];
    logic [127:0] m [4];

    cmac_aes128_ctrl_if bus ();
    cmac_aes128_ctrl_if bus2 ();

    cmac_aes128_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    cmac_aes128_ctrl #(.AES_TIMEOUT(8)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [31:0] w [44];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [31:0] tmp;
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // behavioural AES core: lat cycles after the launch, or 1..20 at random when lat is 0
    initial begin
        logic [127:0] r;
        int n;
        bus.aes_done = 1'b0;
        bus.aes_out  = '0;
        forever begin
            @(negedge clk);
            if (bus.aes_start) begin
                r = aes_enc(bus.aes_key, bus.aes_in);
                n = (lat == 0) ? int'($urandom_range(20, 1)) : lat;
                repeat (n) @(negedge clk);
                bus.aes_out  = r;
                bus.aes_done = 1'b1;
                @(negedge clk);
                bus.aes_done = 1'b0;
            end
        end
    end

    always @(negedge clk) if (bus.tag_valid) tv_cnt++;

    task automatic do_start();
        bus.key   = K;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] d, input bit last, input logic [4:0] nb);
        int b;
        if (gaps) repeat ($urandom_range(3, 0)) @(negedge clk);
        bus.msg_valid = 1'b1;
        bus.msg_data  = d;
        bus.msg_last  = last;
        bus.msg_bytes = last ? nb : 5'($urandom);
        b = 0;
        while (!bus.msg_ready && b < 500) begin
            @(negedge clk);
            b++;
        end
        check("msg_ready", bus.msg_ready, 1);
        @(negedge clk);
        bus.msg_valid = 1'b0;
    endtask

    task automatic run_tag(input string nm, input int nblk, input logic [4:0] nb, input logic [127:0] exp);
        int tv0, b;
        tv0 = tv_cnt;
        do_start();
        for (int i = 0; i < nblk; i++) send_blk(m[i], i == nblk - 1, nb);
        b = 0;
        while (!bus.tag_valid && b < 1000) begin
            @(negedge clk);
            b++;
        end
        check({nm, "_tag_valid"}, bus.tag_valid, 1);
        check({nm, "_tag"}, bus.tag, exp);
        check({nm, "_busy"}, bus.busy, 0);
        @(negedge clk);
        check({nm, "_pulses"}, tv_cnt, tv0 + 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        tv_cnt  = 0;
        lat     = 2;
        gaps    = 0;
        m[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        m[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        m[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        m[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
        reset = 1'b1;
        bus.key = '0; bus.start = 0; bus.msg_valid = 0; bus.msg_data = '0; bus.msg_last = 0; bus.msg_bytes = '0;
        bus2.key = '0; bus2.start = 0; bus2.msg_valid = 0; bus2.msg_data = '0; bus2.msg_last = 0;
        bus2.msg_bytes = '0; bus2.aes_done = 0; bus2.aes_out = '0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {bus.busy, bus.msg_ready, bus.aes_start, bus.tag_valid, bus.error}, 0);
        check("rst_tag", bus.tag, 0);
        check("rst_aes_in", bus.aes_in, 0);
        check("rst_aes_key", bus.aes_key, 0);
        reset = 1'b0;
        @(negedge clk);

        run_tag("empty", 1, 5'd0, T0);
        check("k1", dut.k1_q, K1);
        check("k2", dut.k2_q, K2);
        run_tag("one_blk", 1, 5'd16, T16);
        run_tag("bytes20", 1, 5'd20, T16);
        run_tag("msg40", 3, 5'd8, T40);
        lat  = 0;
        gaps = 1;
        run_tag("msg64", 4, 5'd16, T64);
        gaps = 0;

        lat = 12;
        do_start();
        send_blk(m[0], 0, 5'd0);
        @(negedge clk);
        check("enc_busy", {bus.busy, bus.msg_ready}, 2'b10);
        reset = 1'b1;
        #1;
        check("mid_rst_ctl", {bus.busy, bus.msg_ready, bus.aes_start, bus.tag_valid, bus.error}, 0);
        check("mid_rst_tag", bus.tag, 0);
        check("mid_rst_aes_in", bus.aes_in, 0);
        check("mid_rst_aes_key", bus.aes_key, 0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int tv0;
            tv0 = tv_cnt;
            repeat (20) @(negedge clk);
            check("stray_busy", bus.busy, 0);
            check("stray_pulses", tv_cnt, tv0);
            check("stray_tag", bus.tag, 0);
        end
        lat = 2;
        run_tag("fresh", 1, 5'd16, T16);

        bus2.key   = K;
        bus2.start = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("to_early", {bus2.error, bus2.busy}, 2'b01);
        @(posedge clk);
        #1;
        check("to_err", {bus2.error, bus2.busy, bus2.tag_valid}, 3'b100);
        bus2.start = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        check("to_clear", {bus2.error, bus2.busy}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
